// File: rtl/ads1274_pkg.sv
// Shared definitions for the ADS1274 capture controller: frame geometry,
// strobe placement within the Sync period, and the controller state encoding.
package ads1274_pkg;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CH_W      = 24;
  localparam int unsigned FRAME_W   = NUM_CH * CH_W;
  localparam int unsigned STROBE_AT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_SETTLE,
    ST_ARMED,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/ads1274_capture_ctrl_if.sv
// Captured-frame output stream: head frame, valid flag and consumer acknowledge.
interface ads1274_capture_ctrl_if;
  import ads1274_pkg::*;

  logic [FRAME_W-1:0] Out_Data;
  logic               Out_Valid;
  logic               Out_Ack;

  modport master (output Out_Data, output Out_Valid, input Out_Ack);
  modport slave  (input Out_Data, input Out_Valid, output Out_Ack);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head word.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
  parameter int unsigned WIDTH      = 96,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    head_q, head_d;
  logic                do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign head  = head_q;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    head_d   = head_q;
    // Head must see a same-cycle write landing in the slot that becomes the head.
    if (do_pop) begin
      if (do_push && (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]))
        head_d = push_data;
      else
        head_d = mem_q[rd_ptr_d[DEPTH_LOG2-1:0]];
    end else if (do_push && empty) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/ads1274_capture_ctrl.sv
// ADS1274 capture controller: power-up/resync sequencing, Sync strobe generation,
// settling-frame discard and triggered burst capture into an output FIFO.
module ads1274_capture_ctrl
  import ads1274_pkg::*;
#(
  parameter int unsigned DIVIDE     = 1024,
  parameter int unsigned SYNC_LOW   = 16,
  parameter int unsigned SETTLE     = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   Enable,
  input  logic                   Trigger,
  input  logic [15:0]            Frames,
  output logic                   Sync,
  input  logic [FRAME_W-1:0]     FrameIn,
  output logic [3:0]             ADC_nPWDN,
  output logic                   ADC_nSync,
  output logic                   Busy,
  output logic                   Ready,
  output logic                   Overflow,
  ads1274_capture_ctrl_if.master out_if
);

  localparam int unsigned       DIV_W       = $clog2(DIVIDE);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(DIVIDE - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_STROBE  = DIV_W'(STROBE_AT);
  localparam logic [15:0]       PWRUP_LAST  = 16'(SYNC_LOW - 1);
  localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [15:0]       phase_q, phase_d;
  logic [16:0]       burst_q, burst_d;
  logic              sync_q, sync_d;
  logic [3:0]        npwdn_q, npwdn_d;
  logic              nsync_q, nsync_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              ovf_q, ovf_d;

  logic strobe, push, pop, fifo_full, fifo_empty;

  always_comb begin
    strobe  = (div_q == DIV_STROBE);
    pop     = !fifo_empty && out_if.Out_Ack;
    push    = 1'b0;
    state_d = state_q;
    phase_d = phase_q;
    burst_d = burst_q;
    ovf_d   = ovf_q;
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;

    if (!Enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PWRUP;
          ovf_d   = 1'b0;
        end
        ST_PWRUP: begin
          if (phase_q == PWRUP_LAST) begin
            state_d = ST_SETTLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end
        ST_SETTLE: begin
          if (strobe) begin
            if (phase_q == SETTLE_LAST) begin
              state_d = ST_ARMED;
              phase_d = '0;
            end else begin
              phase_d = phase_q + 16'd1;
            end
          end
        end
        ST_ARMED: begin
          if (Trigger) begin
            state_d = ST_CAPTURE;
            burst_d = (Frames == '0) ? 17'h10000 : {1'b0, Frames};
          end
        end
        ST_CAPTURE: begin
          if (strobe) begin
            push    = 1'b1;
            burst_d = burst_q - 17'd1;
            if (burst_q == 17'd1) state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Leaving IDLE restarts the divider so PWRUP always begins at a Sync pulse.
    if (state_d == ST_IDLE || state_q == ST_IDLE) begin
      div_d   = '0;
      phase_d = '0;
      burst_d = '0;
    end

    // A drop happens only when no pop frees a slot in the same cycle.
    if (push && fifo_full && !pop) ovf_d = 1'b1;

    sync_d  = (state_d != ST_IDLE) && (div_d < DIV_STROBE);
    npwdn_d = (state_d == ST_IDLE) ? 4'h0 : 4'hF;
    nsync_d = (state_d != ST_IDLE) && (state_d != ST_PWRUP);
    busy_d  = state_d inside {ST_PWRUP, ST_SETTLE, ST_CAPTURE};
    ready_d = (state_d == ST_ARMED);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      phase_q <= '0;
      burst_q <= '0;
      sync_q  <= 1'b0;
      npwdn_q <= 4'h0;
      nsync_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      burst_q <= burst_d;
      sync_q  <= sync_d;
      npwdn_q <= npwdn_d;
      nsync_q <= nsync_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Sync      = sync_q;
  assign ADC_nPWDN = npwdn_q;
  assign ADC_nSync = nsync_q;
  assign Busy      = busy_q;
  assign Ready     = ready_q;
  assign Overflow  = ovf_q;

  sync_fifo #(
    .WIDTH      (FRAME_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (nReset),
    .push      (push),
    .push_data (FrameIn),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_if.Out_Data)
  );

  assign out_if.Out_Valid = !fifo_empty;

endmodule

// File: tb/tb_ads1274_capture_ctrl.sv
// Directed bench for ads1274_capture_ctrl: expected frames are queued as FrameIn
// is driven at each strobe and checked in order as the consumer pops them.
module tb_ads1274_capture_ctrl;

  localparam int unsigned DIV        = 16;
  localparam int unsigned SYNC_LOW   = 16;
  localparam int unsigned SETTLE     = 8;
  localparam int unsigned DEPTH_LOG2 = 2;
  localparam int unsigned STROBE     = 4;
  localparam int unsigned FIRST_SETTLE_STROBE =
    SYNC_LOW + ((STROBE + DIV - (SYNC_LOW % DIV)) % DIV);
  localparam int unsigned READY_AT = FIRST_SETTLE_STROBE + (SETTLE - 1) * DIV + 1;
  localparam logic [95:0] GARBAGE = {4{24'h5A5A5A}};

  logic        Clk = 1'b0;
  logic        nReset;
  logic        Enable;
  logic        Trigger;
  logic [15:0] Frames;
  logic        Sync;
  logic [95:0] FrameIn;
  logic [3:0]  ADC_nPWDN;
  logic        ADC_nSync;
  logic        Busy;
  logic        Ready;
  logic        Overflow;

  ads1274_capture_ctrl_if out_if ();

  ads1274_capture_ctrl #(
    .DIVIDE     (DIV),
    .SYNC_LOW   (SYNC_LOW),
    .SETTLE     (SETTLE),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .Enable    (Enable),
    .Trigger   (Trigger),
    .Frames    (Frames),
    .Sync      (Sync),
    .FrameIn   (FrameIn),
    .ADC_nPWDN (ADC_nPWDN),
    .ADC_nSync (ADC_nSync),
    .Busy      (Busy),
    .Ready     (Ready),
    .Overflow  (Overflow),
    .out_if    (out_if)
  );

  always #5 Clk = ~Clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          base   = 0;
  int          seq    = 0;
  logic [95:0] exp_q[$];
  logic [95:0] exp_frame;
  logic [95:0] f;

  function automatic logic [95:0] mk_frame(input int k);
    return {24'(32'hF00000 + k), 24'(32'h0A5000 + k), 24'(32'h003C00 + k), 24'(k)};
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic goto_div(input int d);
    while (((cyc - base) % DIV) != d) step();
  endtask

  // Power-up from IDLE; ev is the Out_Valid level expected throughout.
  task automatic power_up(input logic ev);
    int   rises;
    int   bad;
    logic prev;
    Enable = 1'b1;
    step();
    base = cyc;
    chk("pwrup_npwdn", ADC_nPWDN, 4'hF);
    chk("pwrup_nsync_low", ADC_nSync, 1'b0);
    chk("pwrup_busy", Busy, 1'b1);
    chk("pwrup_ovf_clear", Overflow, 1'b0);
    rises = 0;
    bad   = 0;
    prev  = Sync;
    for (int i = 1; i <= int'(READY_AT); i++) begin
      step();
      if (Sync && !prev) rises++;
      prev = Sync;
      if (out_if.Out_Valid !== ev) bad++;
      if (i == int'(SYNC_LOW) - 1) chk("nsync_still_low", ADC_nSync, 1'b0);
      if (i == int'(SYNC_LOW))     chk("nsync_rise", ADC_nSync, 1'b1);
      if (i == int'(READY_AT) - 1) chk("ready_not_yet", Ready, 1'b0);
    end
    chk("ready_rise", Ready, 1'b1);
    chk("armed_busy", Busy, 1'b0);
    chk("settle_sync_pulses", 96'(rises), 96'(SETTLE));
    chk("valid_during_pwrup", 96'(bad), 96'd0);
  endtask

  always @(negedge Clk) begin
    if (nReset === 1'b1 && out_if.Out_Valid === 1'b1 && out_if.Out_Ack === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_frame observed=%0h expected=none", out_if.Out_Data);
      end
      if (exp_q.size() != 0) begin
        exp_frame = exp_q.pop_front();
        chk("pop_data", out_if.Out_Data, exp_frame);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nReset         = 1'b0;
    Enable         = 1'b0;
    Trigger        = 1'b0;
    Frames         = 16'd0;
    FrameIn        = GARBAGE;
    out_if.Out_Ack = 1'b0;
    step();
    step();
    chk("rst_sync", Sync, 1'b0);
    chk("rst_npwdn", ADC_nPWDN, 4'h0);
    chk("rst_nsync", ADC_nSync, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_ready", Ready, 1'b0);
    chk("rst_ovf", Overflow, 1'b0);
    chk("rst_valid", out_if.Out_Valid, 1'b0);
    chk("rst_data", out_if.Out_Data, 96'd0);
    nReset = 1'b1;
    step();
    chk("idle_npwdn", ADC_nPWDN, 4'h0);

    // Power-up, resync and settle with no FIFO activity.
    power_up(1'b0);

    // Three-frame burst, drained as it arrives.
    out_if.Out_Ack = 1'b1;
    Frames  = 16'd3;
    Trigger = 1'b1;
    step();
    Trigger = 1'b0;
    chk("cap_ready_low", Ready, 1'b0);
    chk("cap_busy", Busy, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      goto_div(STROBE);
      seq++;
      f = mk_frame(seq);
      FrameIn = f;
      exp_q.push_back(f);
      chk("valid_before_strobe", out_if.Out_Valid, 1'b0);
      step();
      FrameIn = GARBAGE;
      chk("valid_after_strobe", out_if.Out_Valid, 1'b1);
    end
    chk("burst3_ready", Ready, 1'b1);
    step();
    chk("burst3_drained", out_if.Out_Valid, 1'b0);

    // Six frames into a four-deep FIFO with the consumer stalled.
    out_if.Out_Ack = 1'b0;
    Frames  = 16'd6;
    Trigger = 1'b1;
    step();
    Trigger = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      goto_div(STROBE);
      seq++;
      f = mk_frame(seq);
      FrameIn = f;
      if (k <= 4) exp_q.push_back(f);
      step();
      FrameIn = GARBAGE;
      chk("ovf_progress", Overflow, (k >= 5) ? 1'b1 : 1'b0);
      if (k == 5) chk("burst6_ready_low", Ready, 1'b0);
    end
    chk("burst6_ready", Ready, 1'b1);

    // Disable while armed: FIFO and Overflow survive, re-enable clears Overflow.
    Enable = 1'b0;
    step();
    chk("dis_npwdn", ADC_nPWDN, 4'h0);
    chk("dis_nsync", ADC_nSync, 1'b0);
    chk("dis_sync", Sync, 1'b0);
    chk("dis_ready", Ready, 1'b0);
    chk("dis_ovf_kept", Overflow, 1'b1);
    chk("dis_valid_kept", out_if.Out_Valid, 1'b1);
    power_up(1'b1);

    // Full FIFO, push and pop in the same cycle.
    Frames  = 16'd1;
    Trigger = 1'b1;
    step();
    Trigger = 1'b0;
    goto_div(STROBE);
    seq++;
    f = mk_frame(seq);
    FrameIn = f;
    exp_q.push_back(f);
    out_if.Out_Ack = 1'b1;
    step();
    out_if.Out_Ack = 1'b0;
    FrameIn = GARBAGE;
    chk("full_pushpop_ovf", Overflow, 1'b0);
    chk("full_pushpop_ready", Ready, 1'b1);
    out_if.Out_Ack = 1'b1;
    repeat (4) step();
    out_if.Out_Ack = 1'b0;
    chk("drain4_empty", out_if.Out_Valid, 1'b0);
    chk("drain4_queue", 96'(exp_q.size()), 96'd0);

    // Enable dropped after 2 of 10 frames.
    Frames  = 16'd10;
    Trigger = 1'b1;
    step();
    Trigger = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      goto_div(STROBE);
      seq++;
      f = mk_frame(seq);
      FrameIn = f;
      exp_q.push_back(f);
      step();
      FrameIn = GARBAGE;
    end
    chk("mid_burst_busy", Busy, 1'b1);
    Enable = 1'b0;
    step();
    chk("abort_npwdn", ADC_nPWDN, 4'h0);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_ready", Ready, 1'b0);
    chk("abort_valid", out_if.Out_Valid, 1'b1);
    out_if.Out_Ack = 1'b1;
    step();
    step();
    out_if.Out_Ack = 1'b0;
    chk("abort_drained", out_if.Out_Valid, 1'b0);
    chk("abort_queue", 96'(exp_q.size()), 96'd0);
    power_up(1'b0);

    // Asynchronous reset in the middle of a capture.
    Frames  = 16'd5;
    Trigger = 1'b1;
    step();
    Trigger = 1'b0;
    goto_div(STROBE);
    FrameIn = mk_frame(99);
    step();
    FrameIn = GARBAGE;
    chk("pre_reset_valid", out_if.Out_Valid, 1'b1);
    goto_div(7);
    #2;
    nReset = 1'b0;
    #1;
    chk("arst_sync", Sync, 1'b0);
    chk("arst_npwdn", ADC_nPWDN, 4'h0);
    chk("arst_nsync", ADC_nSync, 1'b0);
    chk("arst_busy", Busy, 1'b0);
    chk("arst_ready", Ready, 1'b0);
    chk("arst_ovf", Overflow, 1'b0);
    chk("arst_valid", out_if.Out_Valid, 1'b0);
    chk("arst_data", out_if.Out_Data, 96'd0);
    Enable = 1'b0;
    #3;
    nReset = 1'b1;
    step();
    step();
    chk("post_reset_valid", out_if.Out_Valid, 1'b0);
    chk("post_reset_busy", Busy, 1'b0);
    chk("post_reset_npwdn", ADC_nPWDN, 4'h0);
    chk("final_queue", 96'(exp_q.size()), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ads1274_capture_ctrl.md
Name: ads1274_capture_ctrl

Overview:
Controller that sequences the ADS1274 four-channel 24-bit interface block. It powers up and resynchronises the ADC, then generates the periodic Sync latch strobe that interface consumes. It discards settling frames, captures a programmed number of 96-bit frames per trigger, and buffers them in a FIFO with a valid/ready output stream.

Parameters:
DIVIDE, 1024, Clk cycles per frame-latch Sync period; must be at least 8.
SYNC_LOW, 16, Clk cycles ADC_nSync is held low during resync.
SETTLE, 8, frames discarded after resync.
DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 frames.

Ports:
Clk  in  1  system clock, at most 50 MHz, shared with the interface block.
nReset  in  1  asynchronous active-low reset.
Enable  in  1  level input; high runs the ADC, low powers it down.
Trigger  in  1  single-cycle pulse that starts a capture burst.
Frames  in  16  frames per burst, sampled on Trigger; 0 means 65536.
Sync  out  1  frame-latch strobe to the interface block.
FrameIn  in  96  interface DataOut, holding 4x24-bit two's-complement samples.
ADC_nPWDN  out  4  per-channel power-down to the ADC, active low.
ADC_nSync  out  1  ADC SYNC pin, active low.
Busy  out  1  high in PWRUP, SETTLE and CAPTURE.
Ready  out  1  high in ARMED.
Overflow  out  1  sticky; set when a frame arrives with the FIFO full.
Out_Data  out  96  FIFO head frame.
Out_Valid  out  1  FIFO not empty.
Out_Ack  in  1  consumer ready; a frame pops when Out_Valid and Out_Ack are both high.

Behaviour:
- Reset values: state IDLE; Sync 0; ADC_nPWDN 4'b0000; ADC_nSync 0; Busy 0; Ready 0; Overflow 0; Out_Valid 0; Out_Data 0; FIFO empty; all counters 0.
- Frame tick: a free-running divider counts 0..DIVIDE-1 outside IDLE.
  - Sync is high for divider values 0..3 and low otherwise.
  - The interface latches FrameIn two cycles after the Sync rising edge.
  - The controller samples FrameIn at divider value 4; call this the frame strobe.
  - The divider resets to 0 when PWRUP is entered.
- States:
  - IDLE: ADC_nPWDN=0, ADC_nSync=0, divider halted. Enable=1 -> PWRUP.
  - PWRUP: ADC_nPWDN=4'hF, ADC_nSync=0 for SYNC_LOW cycles, then ADC_nSync=1 -> SETTLE.
  - SETTLE: count SETTLE frame strobes without storing them -> ARMED.
  - ARMED: Ready=1. Trigger=1 loads the burst counter with Frames (0 means 65536) -> CAPTURE.
  - CAPTURE: each frame strobe pushes FrameIn and decrements the burst counter. The strobe that takes the counter to 0 -> ARMED.
- Enable=0 in any state -> IDLE on the next cycle. The FIFO contents and Overflow are kept; a burst in progress is abandoned.
- Trigger outside ARMED is ignored. A Trigger on the same cycle as the SETTLE->ARMED transition is ignored.
- Push with the FIFO full: the frame is dropped, Overflow is set, and the burst counter still decrements.
- Push and pop in the same cycle with the FIFO full: the pop frees a slot, so the push is accepted and Overflow is not set.
- Push and pop in the same cycle with the FIFO empty: Out_Valid rises one cycle after the push. There is no fall-through.
- FIFO read and write pointers are DEPTH_LOG2+1 bits wide and wrap naturally. Out_Data is registered at the head and updates on the cycle after a pop.
- Overflow clears only on nReset or on an IDLE->PWRUP transition.
- Latency: a frame strobe reaches Out_Valid one cycle later if the FIFO was empty.

Decomposition:
- Shared package ads1274_pkg holds:
  - the state encoding for IDLE, PWRUP, SETTLE, ARMED and CAPTURE;
  - FRAME_W=96 and CH_W=24;
  - the strobe offset constant STROBE_AT=4.
- One sub-module, sync_fifo: parameterised width and depth log2, with push, pop, full, empty and registered head.

Test Plan:
- Reset, then Enable=1 with DIVIDE=16, SYNC_LOW=16, SETTLE=8 -> ADC_nPWDN=F immediately; ADC_nSync rises after 16 cycles; Ready rises after 8 Sync pulses. No FIFO writes occur before Ready.
- ARMED, Frames=3, Trigger pulse, interface model returning ramp frames 0x1, 0x2, 0x3 -> exactly 3 pushes, each on divider value 4, with Out_Data matching in order. Ready returns after the third push.
- DEPTH_LOG2=2, Out_Ack=0, Frames=6 -> 4 frames stored, Overflow=1 at the fifth strobe, and the state still returns to ARMED after the sixth.
- FIFO full with Out_Ack=1 held during a strobe -> the push is accepted, Overflow stays 0, and the count stays at 4.
- Enable drops mid-burst after 2 of 10 frames -> IDLE next cycle with ADC_nPWDN=0. The 2 frames remain readable; re-enable restarts PWRUP.
- nReset asserted mid-CAPTURE -> all outputs take their reset values asynchronously, and the FIFO is empty after release.
